// File: rtl/down_counter.sv
// Loadable down counter with parallel load, terminal-count pulse and
// selectable end-of-count behaviour (MODE 0 stop, 1 wrap, 2 reload).
module down_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MODE  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             tc,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);
   localparam bit MODE_STOP = (MODE == 32'd0);
   localparam bit MODE_WRAP = (MODE == 32'd1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;
   logic             busy_q;

   // Next-state decode: load beats enable; tc is a single-edge pulse.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      if (load) begin
         count_d  = load_value;
         reload_d = load_value;
         if (MODE_STOP && (load_value == CNT_ZERO)) begin
            state_d = ST_DONE;
         end else begin
            state_d = ST_RUN;
         end
      end else if (enable) begin
         case (state_q)
            ST_IDLE: begin
               // Free-running modes start from the reload value (all ones after reset).
               if (MODE_STOP) begin
                  state_d = ST_IDLE;
               end else begin
                  count_d = reload_q;
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (count_q != CNT_ZERO) begin
                  count_d = count_q - CNT_ONE;
                  if (count_q == CNT_ONE) begin
                     tc_d = 1'b1;
                     if (MODE_STOP) begin
                        state_d = ST_DONE;
                     end else begin
                        state_d = ST_RUN;
                     end
                  end else begin
                     tc_d = 1'b0;
                  end
               end else if (MODE_STOP) begin
                  state_d = ST_DONE;
               end else if (MODE_WRAP) begin
                  count_d = CNT_ONES;
               end else begin
                  // A zero reload value keeps the counter at 0, pulsing tc every edge.
                  count_d = reload_q;
                  if (reload_q == CNT_ZERO) begin
                     tc_d = 1'b1;
                  end else begin
                     tc_d = 1'b0;
                  end
               end
            end
            ST_DONE: begin
               count_d = CNT_ZERO;
            end
            default: begin
               state_d = ST_IDLE;
               count_d = CNT_ZERO;
            end
         endcase
      end else begin
         tc_d = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         count_q  <= CNT_ZERO;
         reload_q <= CNT_ONES;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
         busy_q   <= (state_d == ST_RUN);
      end
   end

   assign count = count_q;
   assign zero  = (count_q == CNT_ZERO);
   assign tc    = tc_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench: one instance per MODE driven by shared stimulus,
// reference model feeding a scoreboard, plus directed checks of key sequences.
module tb_down_counter;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       load;
   logic [3:0] load_value;

   logic [2:0][3:0] dut_cnt;
   logic [2:0]      dut_zero;
   logic [2:0]      dut_tc;
   logic [2:0]      dut_busy;

   int n_asserts = 0;
   int n_fail    = 0;

   typedef struct {
      string      tag;
      int         mode;
      logic [3:0] cnt;
      logic       tc;
      logic       busy;
      logic       zero;
   } exp_t;

   exp_t sb[$];

   // reference model state per mode: st 0=IDLE 1=RUN 2=DONE
   logic [3:0] m_cnt [3];
   logic [3:0] m_rel [3];
   logic       m_tc  [3];
   int         m_st  [3];

   logic [3:0] t3_seq [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
   logic [3:0] t4_seq [7] = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
   logic       t4_tc  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   down_counter #(.WIDTH(4), .MODE(0)) u_m0 (
      .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(load_value),
      .count(dut_cnt[0]), .zero(dut_zero[0]), .tc(dut_tc[0]), .busy(dut_busy[0]));
   down_counter #(.WIDTH(4), .MODE(1)) u_m1 (
      .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(load_value),
      .count(dut_cnt[1]), .zero(dut_zero[1]), .tc(dut_tc[1]), .busy(dut_busy[1]));
   down_counter #(.WIDTH(4), .MODE(2)) u_m2 (
      .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(load_value),
      .count(dut_cnt[2]), .zero(dut_zero[2]), .tc(dut_tc[2]), .busy(dut_busy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_update(input logic r, input logic ld, input logic en, input logic [3:0] lv);
      for (int m = 0; m < 3; m++) begin
         m_tc[m] = 1'b0;
         if (r) begin
            m_cnt[m] = 4'd0;
            m_rel[m] = 4'hF;
            m_st[m]  = 0;
         end else if (ld) begin
            m_cnt[m] = lv;
            m_rel[m] = lv;
            m_st[m]  = (m == 0 && lv == 4'd0) ? 2 : 1;
         end else if (en && m_st[m] == 0 && m != 0) begin
            m_cnt[m] = m_rel[m];
            m_st[m]  = 1;
         end else if (en && m_st[m] == 1) begin
            if (m_cnt[m] == 4'd1) begin
               m_tc[m] = 1'b1;
               if (m == 0) m_st[m] = 2;
            end
            if (m_cnt[m] != 4'd0) m_cnt[m] = m_cnt[m] - 4'd1;
            else if (m == 0) m_st[m] = 2;
            else if (m == 1) m_cnt[m] = 4'hF;
            else begin
               m_cnt[m] = m_rel[m];
               m_tc[m]  = (m_rel[m] == 4'd0);
            end
         end
      end
   endtask

   task automatic step(input string tag, input logic r, input logic ld, input logic en, input logic [3:0] lv);
      exp_t e;
      reset      = r;
      load       = ld;
      enable     = en;
      load_value = lv;
      model_update(r, ld, en, lv);
      for (int m = 0; m < 3; m++) begin
         e.tag  = tag;
         e.mode = m;
         e.cnt  = m_cnt[m];
         e.tc   = m_tc[m];
         e.busy = (m_st[m] == 1);
         e.zero = (m_cnt[m] == 4'd0);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         chk($sformatf("%s m%0d count", e.tag, e.mode), 32'(dut_cnt[e.mode]), 32'(e.cnt));
         chk($sformatf("%s m%0d tc", e.tag, e.mode), 32'(dut_tc[e.mode]), 32'(e.tc));
         chk($sformatf("%s m%0d busy", e.tag, e.mode), 32'(dut_busy[e.mode]), 32'(e.busy));
         chk($sformatf("%s m%0d zero", e.tag, e.mode), 32'(dut_zero[e.mode]), 32'(e.zero));
      end
   endtask

   initial begin
      int tc_n;
      int p1;
      int p2;
      reset = 1'b1; load = 1'b0; enable = 1'b0; load_value = 4'd0;

      // T1 reset
      step("T1", 1'b1, 1'b0, 1'b0, 4'd0);
      step("T1", 1'b1, 1'b0, 1'b0, 4'd0);
      chk("T1 zero flag", 32'(dut_zero[1]), 32'd1);
      chk("T1 busy", 32'(dut_busy[1]), 32'd0);

      // T2 free-running from reset: wrap mode counts 15..0 twice
      tc_n = 0; p1 = 0; p2 = 0;
      for (int k = 1; k <= 34; k++) begin
         step("T2", 1'b0, 1'b0, 1'b1, 4'd0);
         if (k == 1) chk("T2 first count", 32'(dut_cnt[1]), 32'd15);
         if (dut_tc[1] === 1'b1) begin
            tc_n++;
            if (tc_n == 1) p1 = k;
            else p2 = k;
         end
      end
      chk("T2 tc pulses", 32'(tc_n), 32'd2);
      chk("T2 first tc edge", 32'(p1), 32'd16);
      chk("T2 tc spacing", 32'(p2 - p1), 32'd16);
      chk("T2 stop mode idle count", 32'(dut_cnt[0]), 32'd0);

      // T3 one-shot from 5
      step("T3 load", 1'b0, 1'b1, 1'b0, 4'd5);
      chk("T3 loaded", 32'(dut_cnt[0]), 32'd5);
      for (int k = 0; k < 5; k++) begin
         step("T3 run", 1'b0, 1'b0, 1'b1, 4'd0);
         chk($sformatf("T3 seq %0d", k), 32'(dut_cnt[0]), 32'(t3_seq[k]));
      end
      chk("T3 tc at zero", 32'(dut_tc[0]), 32'd1);
      chk("T3 busy fell", 32'(dut_busy[0]), 32'd0);
      tc_n = 0;
      for (int k = 0; k < 10; k++) begin
         step("T3 done", 1'b0, 1'b0, 1'b1, 4'd0);
         if (dut_tc[0] !== 1'b0) tc_n++;
      end
      chk("T3 no tc in done", 32'(tc_n), 32'd0);
      chk("T3 done count", 32'(dut_cnt[0]), 32'd0);

      // T4 reload mode from 3, then reload of 0
      step("T4 load", 1'b0, 1'b1, 1'b0, 4'd3);
      for (int k = 0; k < 7; k++) begin
         step("T4 run", 1'b0, 1'b0, 1'b1, 4'd0);
         chk($sformatf("T4 seq %0d", k), 32'(dut_cnt[2]), 32'(t4_seq[k]));
         chk($sformatf("T4 tc %0d", k), 32'(dut_tc[2]), 32'(t4_tc[k]));
      end
      step("T4 load0", 1'b0, 1'b1, 1'b0, 4'd0);
      chk("T4 no tc on load", 32'(dut_tc[2]), 32'd0);
      for (int k = 0; k < 4; k++) begin
         step("T4 zero", 1'b0, 1'b0, 1'b1, 4'd0);
         chk($sformatf("T4 zero tc %0d", k), 32'(dut_tc[2]), 32'd1);
      end

      // T5 load beats enable, then hold
      step("T5 load4", 1'b0, 1'b1, 1'b0, 4'd4);
      step("T5 both", 1'b0, 1'b1, 1'b1, 4'd9);
      chk("T5 load wins", 32'(dut_cnt[1]), 32'd9);
      for (int k = 0; k < 3; k++) step("T5 hold", 1'b0, 1'b0, 1'b0, 4'd2);
      chk("T5 held", 32'(dut_cnt[1]), 32'd9);

      // T6 reset mid-run at 7
      step("T6 load", 1'b0, 1'b1, 1'b0, 4'd10);
      for (int k = 0; k < 3; k++) step("T6 run", 1'b0, 1'b0, 1'b1, 4'd0);
      chk("T6 at seven", 32'(dut_cnt[0]), 32'd7);
      step("T6 reset", 1'b1, 1'b0, 1'b1, 4'd0);
      chk("T6 reset count", 32'(dut_cnt[0]), 32'd0);
      for (int k = 0; k < 3; k++) step("T6 idle", 1'b0, 1'b0, 1'b1, 4'd0);
      chk("T6 stop mode ignores enable", 32'(dut_busy[0]), 32'd0);
      step("T6 reload", 1'b0, 1'b1, 1'b0, 4'd2);
      step("T6 run2", 1'b0, 1'b0, 1'b1, 4'd0);
      step("T6 run2", 1'b0, 1'b0, 1'b1, 4'd0);
      chk("T6 restart tc", 32'(dut_tc[0]), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
